pipeline_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Holds a scoreboard shift register with one entry per in-flight stage after ID (EX..WB). Each entry stores valid, rd, regwrite and is_load.
- Produces the combinational stall and flush controls for the PC, IF/ID and ID/EX registers, plus registered forwarding selects aligned to EX.
- Keeps saturating stall and flush performance counters.
- Successor to the fixed 5-stage, hazard-free pipeline: depth, branch-resolve stage, load latency and forwarding on/off are all configurable.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_match.sv | 70 +++++++
 rtl/pipeline_hazard_unit.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard/forwarding controller.
//   sb_entry_t : one scoreboard slot (valid, rd, regwrite, is_load)
//   FWD_RF     : forwarding-select code meaning "use the ID/EX register value"
//   sat_inc    : saturating increment for counters up to CNT_MAX_W bits wide
// -----------------------------------------------------------------------------
package hazard_pkg;

    // rd is stored at a fixed maximum width so the entry type stays
    // independent of the REG_AW parameter of any one instance.
    localparam int RD_MAX_W  = 8;
    localparam int CNT_MAX_W = 64;

    // Operand source 0 is the register-file value latched in ID/EX;
    // any other code k selects the result held in scoreboard slot k.
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                is_load;
    } sb_entry_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [CNT_MAX_W-1:0] sat_inc(
        input logic [CNT_MAX_W-1:0] v,
        input int                   w
    );
        logic [CNT_MAX_W-1:0] max_v;
        max_v = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - w);
        return (v >= max_v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Youngest-match priority encoder for one ID source operand against the
// scoreboard, plus the stall/forward classification of that match.
//   i_sb    : scoreboard slots, index 0 = EX (youngest)
//   i_rs    : ID source register
//   i_use   : the source is actually read
//   o_idx   : slot index j of the youngest match
//   o_stall : this operand needs ID held this cycle
//   o_fwd   : this operand can be forwarded from slot j+1 at EX time
// -----------------------------------------------------------------------------
module hazard_match
    import hazard_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int PIPE_DEPTH = 3,
    parameter  int LOAD_READY = 2,
    parameter  int FWD_EN     = 1,
    parameter  int RF_WT      = 0,
    localparam int IDX_W      = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1
) (
    input  sb_entry_t [PIPE_DEPTH-1:0] i_sb,
    input  logic [REG_AW-1:0]          i_rs,
    input  logic                       i_use,
    output logic [IDX_W-1:0]           o_idx,
    output logic                       o_stall,
    output logic                       o_fwd
);

    always_comb begin
        logic hit;
        logic ld;
        int   k;
        // NOTE: every output and local gets a default before any branch so
        // no path leaves a value held, which would infer a latch.
        hit     = 1'b0;
        ld      = 1'b0;
        k       = 0;
        o_idx   = '0;
        o_stall = 1'b0;
        o_fwd   = 1'b0;

        // Scan oldest to youngest so the lowest matching index wins.
        for (int j = PIPE_DEPTH - 1; j >= 0; j--) begin
            if (i_use && (i_rs != '0) && i_sb[j].valid && i_sb[j].regwrite &&
                (i_sb[j].rd == RD_MAX_W'(i_rs))) begin
                hit   = 1'b1;
                ld    = i_sb[j].is_load;
                o_idx = IDX_W'(j);
                k     = j + 1;
            end
        end

        // k is where the producer sits when this consumer reaches EX.
        if (hit) begin
            if (k >= PIPE_DEPTH) begin
                // Producer has retired by then: only the register file can
                // supply the value, and only a write-through file in time.
                o_stall = (RF_WT == 0);
            end else if (FWD_EN == 0) begin
                o_stall = 1'b1;
            end else if (ld && (k < LOAD_READY)) begin
                o_stall = 1'b1;
            end else begin
                o_fwd = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
// Hazard and forwarding controller for the in-order pipeline. Tracks the
// instructions in EX..WB in a scoreboard shift register and produces:
//   o_stall      : hold PC and IF/ID, bubble into ID/EX (combinational)
//   o_flush      : clear IF/ID and ID/EX on a taken branch (combinational)
//   o_fwd_a_sel  : EX operand A source, registered (0 = ID/EX, k = slot k)
//   o_fwd_b_sel  : EX operand B source, registered
//   o_stall_cnt  : saturating count of stall cycles
//   o_flush_cnt  : saturating count of flush cycles
// Inputs are the ID-stage instruction fields, the taken-branch report from
// slot BR_STAGE, clock i_clk and synchronous active-high reset i_rst.
// -----------------------------------------------------------------------------
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int PIPE_DEPTH = 3,
    parameter  int BR_STAGE   = 1,
    parameter  int LOAD_READY = 2,
    parameter  int FWD_EN     = 1,
    parameter  int RF_WT      = 0,
    parameter  int CNT_W      = 32,
    localparam int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_regwrite,
    input  logic              i_id_is_load,
    input  logic              i_branch_taken,
    output logic              o_stall,
    output logic              o_flush,
    output logic [SEL_W-1:0]  o_fwd_a_sel,
    output logic [SEL_W-1:0]  o_fwd_b_sel,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam int IDX_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    sb_entry_t [PIPE_DEPTH-1:0] sb_q;
    sb_entry_t [PIPE_DEPTH-1:0] sb_d;

    logic [IDX_W-1:0] idx_a, idx_b;
    logic             haz_a, haz_b;
    logic             fwd_a, fwd_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             id_adv;

    hazard_match #(
        .REG_AW     (REG_AW),
        .PIPE_DEPTH (PIPE_DEPTH),
        .LOAD_READY (LOAD_READY),
        .FWD_EN     (FWD_EN),
        .RF_WT      (RF_WT)
    ) u_match_a (
        .i_sb    (sb_q),
        .i_rs    (i_id_rs1),
        .i_use   (i_id_use_rs1),
        .o_idx   (idx_a),
        .o_stall (haz_a),
        .o_fwd   (fwd_a)
    );

    hazard_match #(
        .REG_AW     (REG_AW),
        .PIPE_DEPTH (PIPE_DEPTH),
        .LOAD_READY (LOAD_READY),
        .FWD_EN     (FWD_EN),
        .RF_WT      (RF_WT)
    ) u_match_b (
        .i_sb    (sb_q),
        .i_rs    (i_id_rs2),
        .i_use   (i_id_use_rs2),
        .o_idx   (idx_b),
        .o_stall (haz_b),
        .o_fwd   (fwd_b)
    );

    // Flush has priority: a stall never asserts in a flush cycle, so the
    // ID instruction is simply discarded rather than held.
    assign o_flush = i_branch_taken;
    assign o_stall = i_id_valid & (haz_a | haz_b) & ~o_flush;
    assign id_adv  = i_id_valid & ~o_stall & ~o_flush;

    assign sel_a = fwd_a ? SEL_W'(idx_a) + SEL_W'(1) : SEL_W'(FWD_RF);
    assign sel_b = fwd_b ? SEL_W'(idx_b) + SEL_W'(1) : SEL_W'(FWD_RF);

    always_comb begin
        sb_d = '0;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
            // Instructions younger than the branch are on the wrong path.
            if (o_flush && (i <= BR_STAGE)) begin
                sb_d[i].valid = 1'b0;
            end
        end
        if (id_adv) begin
            sb_d[0] = '{valid:    1'b1,
                        rd:       RD_MAX_W'(i_id_rd),
                        regwrite: i_id_regwrite,
                        is_load:  i_id_is_load};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the scoreboard is a handful of flops, not a RAM, so it is
            // cleared wholesale; its valid bits gate every hazard decision.
            sb_q        <= '0;
            o_fwd_a_sel <= SEL_W'(FWD_RF);
            o_fwd_b_sel <= SEL_W'(FWD_RF);
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            sb_q        <= sb_d;
            o_fwd_a_sel <= id_adv ? sel_a : SEL_W'(FWD_RF);
            o_fwd_b_sel <= id_adv ? sel_b : SEL_W'(FWD_RF);
            if (o_stall) begin
                o_stall_cnt <= CNT_W'(sat_inc(CNT_MAX_W'(o_stall_cnt), CNT_W));
            end
            if (o_flush) begin
                o_flush_cnt <= CNT_W'(sat_inc(CNT_MAX_W'(o_flush_cnt), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_unit
// Directed bench for pipeline_hazard_unit. Three instances share one set of
// ID/branch inputs:
//   dut    : defaults (forwarding on, 32-bit counters)
//   dut_nf : FWD_EN=0, RF_WT=0, CNT_W=4
//   dut_nw : FWD_EN=0, RF_WT=1, CNT_W=4
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
    logic       branch_taken;

    logic        m_stall, m_flush;
    logic [1:0]  m_sa, m_sb;
    logic [31:0] m_sc, m_fc;

    logic        nf_stall, nf_flush;
    logic [1:0]  nf_sa, nf_sb;
    logic [3:0]  nf_sc, nf_fc;

    logic        nw_stall, nw_flush;
    logic [1:0]  nw_sa, nw_sb;
    logic [3:0]  nw_sc, nw_fc;

    int checks   = 0;
    int failures = 0;
    int nf_n, nw_n;

    always #5 clk = ~clk;

    pipeline_hazard_unit dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_regwrite(id_regwrite), .i_id_is_load(id_is_load),
        .i_branch_taken(branch_taken),
        .o_stall(m_stall), .o_flush(m_flush),
        .o_fwd_a_sel(m_sa), .o_fwd_b_sel(m_sb),
        .o_stall_cnt(m_sc), .o_flush_cnt(m_fc)
    );

    pipeline_hazard_unit #(.FWD_EN(0), .RF_WT(0), .CNT_W(4)) dut_nf (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_regwrite(id_regwrite), .i_id_is_load(id_is_load),
        .i_branch_taken(branch_taken),
        .o_stall(nf_stall), .o_flush(nf_flush),
        .o_fwd_a_sel(nf_sa), .o_fwd_b_sel(nf_sb),
        .o_stall_cnt(nf_sc), .o_flush_cnt(nf_fc)
    );

    pipeline_hazard_unit #(.FWD_EN(0), .RF_WT(1), .CNT_W(4)) dut_nw (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_regwrite(id_regwrite), .i_id_is_load(id_is_load),
        .i_branch_taken(branch_taken),
        .o_stall(nw_stall), .o_flush(nw_flush),
        .o_fwd_a_sel(nw_sa), .o_fwd_b_sel(nw_sb),
        .o_stall_cnt(nw_sc), .o_flush_cnt(nw_fc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic id_op(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
    endtask

    task automatic nop();
        id_op(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        nop();
        repeat (n) tick();
    endtask

    initial begin
        rst          = 1'b1;
        branch_taken = 1'b0;
        nop();
        tick();
        tick();

        // Reset state
        #1;
        check("rst_stall",    m_stall, 1'b0);
        check("rst_flush",    m_flush, 1'b0);
        check("rst_sel_a",    m_sa, 2'd0);
        check("rst_sel_b",    m_sb, 2'd0);
        check("rst_stall_cnt", m_sc, 32'd0);
        check("rst_flush_cnt", m_fc, 32'd0);
        check("rst_nf_cnt",   nf_sc, 4'd0);
        check("rst_slot0",    dut.sb_q[0].valid, 1'b0);
        rst = 1'b0;
        tick();

        // ALU -> ALU: forward from slot 1, no stall
        id_op(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        #1 check("fwd_prod_stall", m_stall, 1'b0);
        tick();
        id_op(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        #1 check("fwd_cons_stall", m_stall, 1'b0);
        tick();
        nop();
        #1;
        check("fwd_a_sel", m_sa, 2'd1);
        check("fwd_b_sel", m_sb, 2'd0);
        drain(3);

        // Load-use: one stall cycle, bubble, then forward from slot 2
        id_op(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        id_op(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1 check("lu_stall", m_stall, 1'b1);
        tick();
        #1;
        check("lu_bubble",      dut.sb_q[0].valid, 1'b0);
        check("lu_slot1_rd",    dut.sb_q[1].rd, 8'd7);
        check("lu_stall_clear", m_stall, 1'b0);
        tick();
        nop();
        #1;
        check("lu_sel_a",     m_sa, 2'd2);
        check("lu_sel_b",     m_sb, 2'd2);
        check("lu_stall_cnt", m_sc, 32'd1);
        drain(3);

        // Taken branch in slot 1 with slots 0 and 1 valid
        id_op(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        id_op(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        id_op(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
        branch_taken = 1'b1;
        #1;
        check("br_flush", m_flush, 1'b1);
        check("br_stall", m_stall, 1'b0);
        tick();
        branch_taken = 1'b0;
        nop();
        #1;
        check("br_slot0_valid", dut.sb_q[0].valid, 1'b0);
        check("br_slot1_valid", dut.sb_q[1].valid, 1'b0);
        check("br_slot2_valid", dut.sb_q[2].valid, 1'b1);
        check("br_slot2_rd",    dut.sb_q[2].rd, 8'd10);
        check("br_flush_cnt",   m_fc, 32'd1);
        drain(3);

        // Load-use and branch together: flush wins
        id_op(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        id_op(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        branch_taken = 1'b1;
        #1;
        check("lubr_stall", m_stall, 1'b0);
        check("lubr_flush", m_flush, 1'b1);
        tick();
        branch_taken = 1'b0;
        nop();
        #1;
        check("lubr_slot0_valid", dut.sb_q[0].valid, 1'b0);
        check("lubr_stall_cnt",   m_sc, 32'd1);
        check("lubr_flush_cnt",   m_fc, 32'd2);
        check("lubr_sel_a",       m_sa, 2'd0);
        drain(3);

        // x0 is never a dependency
        id_op(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        id_op(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        check("x0_stall",    m_stall, 1'b0);
        check("x0_nf_stall", nf_stall, 1'b0);
        tick();
        nop();
        #1;
        check("x0_sel_a", m_sa, 2'd0);
        check("x0_sel_b", m_sb, 2'd0);
        drain(4);

        // Forwarding disabled: producer in slots 0,1,2 stalls; the WB slot
        // is exempt only with a write-through register file.
        id_op(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        id_op(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        nf_n = 0;
        nw_n = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (nf_stall) nf_n++;
            if (nw_stall) nw_n++;
            tick();
        end
        check("nofwd_stalls",    nf_n, 3);
        check("nofwd_wt_stalls", nw_n, 2);
        drain(4);

        // Reset asserted during a load-use stall
        id_op(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        id_op(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1 check("rm_stall_before", m_stall, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rm_stall",     m_stall, 1'b0);
        check("rm_sel_a",     m_sa, 2'd0);
        check("rm_sel_b",     m_sb, 2'd0);
        check("rm_stall_cnt", m_sc, 32'd0);
        check("rm_flush_cnt", m_fc, 32'd0);
        check("rm_nf_cnt",    nf_sc, 4'd0);
        check("rm_slot1",     dut.sb_q[1].valid, 1'b0);
        drain(4);

        // Back-to-back self-dependent ops: the 4-bit counters saturate,
        // while the forwarding instance never stalls.
        id_op(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        repeat (30) tick();
        #1;
        check("sat_nf_cnt",   nf_sc, 4'hF);
        check("sat_nw_cnt",   nw_sc, 4'hF);
        check("sat_main_cnt", m_sc, 32'd0);
        check("sat_main_sel", m_sa, 2'd1);
        nop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
